// File: rtl/cpu_clk_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : cpu_clk_ctrl_if
// Brief    : Control/status bundle between the CPU clock controller and the
//            FPGA top level (mode, divider, debug inputs, divided clock out).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cpu_clk_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int PC_W  = 32
);
  logic [1:0]       MODE;
  logic [CNT_W-1:0] DIV;
  logic             STEP_BTN;
  logic [PC_W-1:0]  PC_IN;
  logic [PC_W-1:0]  BREAK_PC;
  logic             CLK;
  logic             CLK_EN;
  logic [31:0]      CYCLE_CNT;
  logic             HALTED;
  logic             BREAK_HIT;

  // master drives the controls, slave is the clock controller itself
  modport master (
    output MODE, DIV, STEP_BTN, PC_IN, BREAK_PC,
    input  CLK, CLK_EN, CYCLE_CNT, HALTED, BREAK_HIT
  );

  modport slave (
    input  MODE, DIV, STEP_BTN, PC_IN, BREAK_PC,
    output CLK, CLK_EN, CYCLE_CNT, HALTED, BREAK_HIT
  );
endinterface

`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
//------------------------------------------------------------------------------
// Module   : cpu_clk_ctrl
// Brief    : Programmable, glitch-free CPU clock with halt, run, debounced
//            single-step and run-to-breakpoint modes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_clk_ctrl #(
  parameter int CNT_W      = 32,
  parameter int DEB_CYCLES = 1000000,
  parameter int PC_W       = 32
) (
  input  logic          CLK_GEN,
  input  logic          RST,
  cpu_clk_ctrl_if.slave bus
);

  localparam int               DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_BRK  = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic             clk_q,      clk_d;
  logic             clk_en_q,   clk_en_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] div_q,      div_d;
  logic [31:0]      cyc_q,      cyc_d;
  logic             halted_q,   halted_d;
  logic             brk_hit_q,  brk_hit_d;
  logic             rose_q,     rose_d;
  logic             from_brk_q, from_brk_d;
  logic             sync1_q,    sync1_d;
  logic             sync2_q,    sync2_d;
  logic [DEB_W-1:0] deb_cnt_q,  deb_cnt_d;
  logic             deb_lvl_q,  deb_lvl_d;
  logic             step_evt_q, step_evt_d;

  logic [PC_W-1:0]  w_pc_xor;
  logic             w_pc_match;
  logic             w_terminal;
  logic             w_rise;

  assign w_pc_xor   = bus.PC_IN ^ bus.BREAK_PC;
  assign w_pc_match = ~|w_pc_xor;
  assign w_terminal = (cnt_q == div_q);

  // Debouncer: the level follows the synchronised pin only after DEB_CYCLES
  // consecutive samples disagreeing with it; any agreeing sample restarts.
  always_comb begin
    sync1_d    = bus.STEP_BTN;
    sync2_d    = sync1_q;
    deb_cnt_d  = '0;
    deb_lvl_d  = deb_lvl_q;
    step_evt_d = 1'b0;
    if (sync2_q != deb_lvl_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_lvl_d  = sync2_q;
        step_evt_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_d      = clk_q;
    clk_en_d   = 1'b0;
    cnt_d      = cnt_q;
    div_d      = div_q;
    cyc_d      = cyc_q;
    brk_hit_d  = brk_hit_q;
    rose_d     = rose_q;
    from_brk_d = from_brk_q;
    w_rise     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.MODE[0]) begin
          state_d = S_RUN;
          div_d   = bus.DIV;
        end else if (step_evt_q) begin
          state_d    = S_STEP;
          div_d      = bus.DIV;
          rose_d     = 1'b0;
          from_brk_d = 1'b0;
        end
      end

      S_BRK: begin
        cnt_d = '0;
        if (bus.MODE != 2'b11) begin
          state_d   = S_IDLE;
          div_d     = bus.DIV;
          brk_hit_d = 1'b0;
        end else if (step_evt_q) begin
          state_d    = S_STEP;
          div_d      = bus.DIV;
          rose_d     = 1'b0;
          from_brk_d = 1'b1;
        end
      end

      S_RUN, S_STEP: begin
        if (!w_terminal) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (clk_q) begin
            clk_d = 1'b0;
            div_d = bus.DIV;
          end else if (state_q == S_STEP) begin
            // A step always ends on a complete low phase before parking again.
            if (rose_q) begin
              state_d = from_brk_q ? S_BRK : S_IDLE;
            end else begin
              w_rise = 1'b1;
              rose_d = 1'b1;
            end
          end else if (!bus.MODE[0]) begin
            state_d = S_IDLE;
          end else if (bus.MODE[1] && w_pc_match) begin
            state_d   = S_BRK;
            brk_hit_d = 1'b1;
          end else begin
            w_rise = 1'b1;
          end
        end
      end
    endcase

    if (w_rise) begin
      clk_d    = 1'b1;
      clk_en_d = 1'b1;
      cyc_d    = cyc_q + 32'd1;
      div_d    = bus.DIV;
    end

    // Parked, or running low with a halt already requested.
    halted_d = (state_d == S_IDLE) || (state_d == S_BRK) ||
               ((state_d == S_RUN) && !clk_d && !bus.MODE[0]);
  end

  always_ff @(posedge CLK_GEN or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      clk_q      <= 1'b0;
      clk_en_q   <= 1'b0;
      cnt_q      <= '0;
      div_q      <= '0;
      cyc_q      <= '0;
      halted_q   <= 1'b1;
      brk_hit_q  <= 1'b0;
      rose_q     <= 1'b0;
      from_brk_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_cnt_q  <= '0;
      deb_lvl_q  <= 1'b0;
      step_evt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_q      <= clk_d;
      clk_en_q   <= clk_en_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      cyc_q      <= cyc_d;
      halted_q   <= halted_d;
      brk_hit_q  <= brk_hit_d;
      rose_q     <= rose_d;
      from_brk_q <= from_brk_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      step_evt_q <= step_evt_d;
    end
  end

  assign bus.CLK       = clk_q;
  assign bus.CLK_EN    = clk_en_q;
  assign bus.CYCLE_CNT = cyc_q;
  assign bus.HALTED    = halted_q;
  assign bus.BREAK_HIT = brk_hit_q;

endmodule

`default_nettype wire
